seq_array_multiplier: RTL and testbench
=======================================

Name: seq_array_multiplier

Overview:
- Parametrised, iterative shift-add multiplier; successor to the fixed 8x8 combinational array multiplier in the TinyTapeout top.
- Trades area for latency: one partial product per cycle, WIDTH cycles per product.
- Valid/ready handshakes on input and output so the top-level wrapper can drive it from ui_in/uio_in and stall on uo_out readout.

Parameters:
- WIDTH, 8, operand width in bits (legal 2..32); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  result
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; in_ready=1, out_valid=0, busy=0, product=0, counter=0, accumulator=0. Applies mid-operation; the in-flight product is discarded and never presented.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: latch a to a 2*WIDTH shift register (zero-extended), latch b to a WIDTH shift register, clear accumulator and counter, go BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: if b_reg[0]=1 then acc += a_reg, computed mod 2^(2*WIDTH); then a_reg <<= 1, b_reg >>= 1, counter += 1.
  - After exactly WIDTH BUSY cycles (edges T+1..T+WIDTH): product register <= final acc, go DONE.
  - No early termination, even for b=0.
- DONE:
  - out_valid=1 from cycle T+WIDTH+1.
  - product is held stable while out_valid=1 and out_ready=0 (arbitrary stall length).
  - On out_valid&out_ready: go IDLE; out_valid=0 next cycle.
  - New operands are not accepted in the same cycle as output acceptance.
- Latency and throughput: accept-to-out_valid = WIDTH+1 cycles; minimum initiation interval = WIDTH+2 cycles.
- product retains its last value in IDLE and BUSY; consumers qualify it with out_valid only.
- in_valid while in_ready=0 is ignored; a and b are not sampled.
- Arithmetic is unsigned by default. Max case (2^WIDTH-1)^2 fits in 2*WIDTH bits, so overflow is impossible.
- X on out_ready outside DONE has no effect.

Optional Feature:
- Macro: SEQ_MUL_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled together with a/b on acceptance.
  - signed_mode=1: a and b are two's complement. Magnitudes |a| and |b| are latched, the unsigned iteration runs unchanged, and the final acc is negated if the sign bits differ, in the same edge that loads product.
  - -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) is exact.
  - Latency unchanged.
  - signed_mode=0: identical to the unsigned behaviour.
- Not defined: port absent; unsigned only; no sign logic synthesised.

Test Plan:
- WIDTH=8, reset then a=13, b=11 -> out_valid exactly 9 cycles after accept, product=16'h008F (143); in_ready low from accept until after output handshake.
- WIDTH=8, a=255, b=255 -> product=16'hFE01; then a=0, b=200 -> product=0, same 9-cycle latency.
- Backpressure: a=7, b=6, hold out_ready=0 for 20 cycles -> out_valid stays 1 and product stays 16'h002A; in_valid pulses during the stall ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-op: accept a=100, b=3, assert rst at BUSY cycle 4 -> all outputs return to reset values next cycle, no out_valid; next op a=2, b=3 -> 16'h0006.
- WIDTH=16 regression: 1000 random operand pairs with random out_ready stalls -> every product equals a*b, 17-cycle latency, no dropped or duplicated results.
- SEQ_MUL_SIGNED_EN, WIDTH=8, signed_mode=1: -3*5 -> 16'hFFF1; -128*-128 -> 16'h4000; -1*-1 -> 16'h0001; signed_mode=0 with 8'hFD*5 -> 16'h04F1.

Source files
------------

// File: rtl/seq_array_multiplier_if.sv
// Valid/ready operand and product bus for seq_array_multiplier.
// The signed_mode signal exists only when SEQ_MUL_SIGNED_EN is defined.
interface seq_array_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;
`ifdef SEQ_MUL_SIGNED_EN
  logic               signed_mode;
`endif

  modport master (
    output in_valid, a, b, out_ready,
`ifdef SEQ_MUL_SIGNED_EN
    output signed_mode,
`endif
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef SEQ_MUL_SIGNED_EN
    input  signed_mode,
`endif
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// Optional two's complement mode is enabled by defining SEQ_MUL_SIGNED_EN.
module seq_array_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            rst,
  seq_array_multiplier_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] final_val;
  logic [2*WIDTH-1:0] product_reg;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               busy_reg;

`ifdef SEQ_MUL_SIGNED_EN
  logic               neg_reg;
  logic               neg_in;

  // Magnitudes feed the unsigned core; the sign is reapplied when product loads.
  always_comb begin
    a_mag     = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    neg_in    = bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    acc_next  = acc + (b_reg[0] ? a_reg : '0);
    final_val = neg_reg ? -acc_next : acc_next;
  end
`else
  always_comb begin
    a_mag     = bus.a;
    b_mag     = bus.b;
    acc_next  = acc + (b_reg[0] ? a_reg : '0);
    final_val = acc_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      cnt           <= '0;
      product_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_reg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= {{WIDTH{1'b0}}, a_mag};
            b_reg        <= b_mag;
            acc          <= '0;
            cnt          <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state        <= BUSY;
`ifdef SEQ_MUL_SIGNED_EN
            neg_reg      <= neg_in;
`endif
          end
        end
        // Always runs the full WIDTH iterations so latency is data independent.
        BUSY: begin
          acc   <= acc_next;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            product_reg   <= final_val;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end
        end
        // Returning to IDLE here keeps in_ready low on the handshake cycle.
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.product   = product_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed and short random checks for seq_array_multiplier at WIDTH=8.
// Signed vectors are added when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_array_multiplier;

  localparam int WIDTH   = 8;
  localparam int LATENCY = WIDTH + 1;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sm;
    logic [2*WIDTH-1:0] expected;
    int                 stall;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];

  seq_array_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_array_multiplier #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic set_sm(input logic sm);
`ifdef SEQ_MUL_SIGNED_EN
    bus.signed_mode = sm;
`else
    if (sm) $display("[TB] signed_mode requested in unsigned build, ignored");
`endif
  endtask

  // One full transaction: accept, latency count, optional stall with ignored pulses, handshake.
  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic sm, input logic [2*WIDTH-1:0] expected,
                                input int stall, input string name);
    int cycles;
    bit busy_ok;
    bit stall_ok;
    @(negedge clk);
    check_output({name, " in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    set_sm(sm);
    @(posedge clk);
    cycles  = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = '1;
      bus.b        = '1;
      set_sm(1'b0);
      cycles++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) busy_ok = 1'b0;
    end while (bus.out_valid !== 1'b1 && cycles < 4 * LATENCY);
    check_output({name, " latency"}, 64'(cycles), 64'(LATENCY));
    check_output({name, " busy_handshake"}, 64'(busy_ok), 64'd1);
    check_output({name, " product"}, 64'(bus.product), 64'(expected));
    stall_ok = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a        = 8'h5A;
      bus.b        = 8'hA5;
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.product !== expected || bus.in_ready !== 1'b0)
        stall_ok = 1'b0;
    end
    if (stall > 0) check_output({name, " stall_hold"}, 64'(stall_ok), 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_output({name, " after_hs_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({name, " after_hs_ready"}, 64'(bus.in_ready), 64'd1);
    check_output({name, " after_hs_product"}, 64'(bus.product), 64'(expected));
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    bit               no_valid;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    set_sm(1'b0);

    vecs.push_back('{8'd13,  8'd11,  1'b0, 16'h008F, 0});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 16'hFE01, 0});
    vecs.push_back('{8'd0,   8'd200, 1'b0, 16'h0000, 0});
    vecs.push_back('{8'd7,   8'd6,   1'b0, 16'h002A, 20});
    vecs.push_back('{8'd1,   8'd255, 1'b0, 16'h00FF, 2});
    vecs.push_back('{8'd128, 8'd2,   1'b0, 16'h0100, 1});
    vecs.push_back('{8'd200, 8'd0,   1'b0, 16'h0000, 0});
`ifdef SEQ_MUL_SIGNED_EN
    vecs.push_back('{8'hFD,  8'd5,   1'b1, 16'hFFF1, 0});
    vecs.push_back('{8'h80,  8'h80,  1'b1, 16'h4000, 0});
    vecs.push_back('{8'hFF,  8'hFF,  1'b1, 16'h0001, 3});
    vecs.push_back('{8'hFD,  8'd5,   1'b0, 16'h04F1, 0});
    vecs.push_back('{8'd3,   8'hFE,  1'b1, 16'hFFFA, 0});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("reset in_ready", 64'(bus.in_ready), 64'd1);
    check_output("reset out_valid", 64'(bus.out_valid), 64'd0);
    check_output("reset busy", 64'(bus.busy), 64'd0);
    check_output("reset product", 64'(bus.product), 64'd0);

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].expected, vecs[i].stall,
                     $sformatf("vec%0d", i));

    // Reset during BUSY: the in-flight product must never appear.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'd100;
    bus.b        = 8'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("midrst in_ready", 64'(bus.in_ready), 64'd1);
    check_output("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check_output("midrst busy", 64'(bus.busy), 64'd0);
    check_output("midrst product", 64'(bus.product), 64'd0);
    no_valid = 1'b1;
    repeat (2 * LATENCY) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) no_valid = 1'b0;
    end
    check_output("midrst no_result", 64'(no_valid), 64'd1);
    apply_stimulus(8'd2, 8'd3, 1'b0, 16'h0006, 0, "post_rst");

    // Random unsigned pairs with random consumer stalls.
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      apply_stimulus(ra, rb, 1'b0, 16'(ra) * 16'(rb), int'($urandom_range(0, 3)),
                     $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
